// File: rtl/arcade_round_ctrl_if.sv
// Handshake/status bundle between the button/DIP front end and the round sequencer.
interface arcade_round_ctrl_if #(
    parameter int unsigned CREDIT_W = 9
);
    logic                start_pulse;
    logic                stop_pulse;
    logic                restart_pulse;
    logic [6:0]          bet_sel;
    logic [3:0]          guess_digit;
    logic [3:0]          rand_digit;
    logic [1:0]          state;
    logic [CREDIT_W-1:0] credit;
    logic [2:0]          bet;
    logic [3:0]          result_digit;
    logic                win;
    logic                spin_en;
    logic                start_rej;
    logic                timeout_flag;

    modport master (
        output start_pulse, stop_pulse, restart_pulse, bet_sel, guess_digit, rand_digit,
        input  state, credit, bet, result_digit, win, spin_en, start_rej, timeout_flag
    );

    modport slave (
        input  start_pulse, stop_pulse, restart_pulse, bet_sel, guess_digit, rand_digit,
        output state, credit, bet, result_digit, win, spin_en, start_rej, timeout_flag
    );
endinterface

// File: rtl/arcade_round_ctrl.sv
// Round sequencer and credit manager: bet -> spin -> show -> (game over), with
// bet validation, saturating win payout and automatic spin timeout.
module arcade_round_ctrl #(
    parameter int unsigned CREDIT_W     = 9,
    parameter int unsigned CREDIT_INIT  = 200,
    parameter int unsigned CREDIT_MAX   = 511,
    parameter int unsigned SPIN_TIMEOUT = 1000
) (
    input  logic                      clk,
    input  logic                      rstn,
    arcade_round_ctrl_if.slave        bus
);
    localparam int unsigned TIMER_W = $clog2(SPIN_TIMEOUT);
    localparam int unsigned SUM_W   = CREDIT_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        SHOW = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [2:0]          bet_q, bet_d;
    logic [3:0]          guess_q, guess_d;
    logic [3:0]          result_q, result_d;
    logic                win_q, win_d;
    logic                spin_en_q, spin_en_d;
    logic                start_rej_q, start_rej_d;
    logic                timeout_q, timeout_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;

    logic [2:0]          bet_cnt;
    logic [SUM_W-1:0]    payout_sum;
    logic                hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            credit_q    <= CREDIT_W'(CREDIT_INIT);
            bet_q       <= '0;
            guess_q     <= '0;
            result_q    <= '0;
            win_q       <= 1'b0;
            spin_en_q   <= 1'b0;
            start_rej_q <= 1'b0;
            timeout_q   <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            bet_q       <= bet_d;
            guess_q     <= guess_d;
            result_q    <= result_d;
            win_q       <= win_d;
            spin_en_q   <= spin_en_d;
            start_rej_q <= start_rej_d;
            timeout_q   <= timeout_d;
            timer_q     <= timer_d;
        end
    end

    // Next-state and registered-output logic; only the pulse relevant to the state is used.
    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        bet_d       = bet_q;
        guess_d     = guess_q;
        result_d    = result_q;
        win_d       = win_q;
        spin_en_d   = spin_en_q;
        start_rej_d = 1'b0;
        timeout_d   = timeout_q;
        timer_d     = timer_q;
        bet_cnt     = 3'($countones(bus.bet_sel));
        payout_sum  = SUM_W'(credit_q) + SUM_W'({bet_q, 1'b0});
        // Latched guess is always 0..9, so a rand_digit above 9 can never match.
        hit         = (bus.rand_digit == guess_q);

        unique case (state_q)
            IDLE: begin
                if (bus.start_pulse) begin
                    if ((bet_cnt != 3'd0) && (CREDIT_W'(bet_cnt) <= credit_q)
                        && (bus.guess_digit <= 4'd9)) begin
                        bet_d     = bet_cnt;
                        guess_d   = bus.guess_digit;
                        credit_d  = credit_q - CREDIT_W'(bet_cnt);
                        timer_d   = '0;
                        spin_en_d = 1'b1;
                        state_d   = SPIN;
                    end else begin
                        start_rej_d = 1'b1;
                    end
                end
            end
            SPIN: begin
                timer_d = timer_q + TIMER_W'(1);
                if (bus.stop_pulse || (timer_q == TIMER_W'(SPIN_TIMEOUT - 1))) begin
                    result_d  = bus.rand_digit;
                    win_d     = hit;
                    timeout_d = !bus.stop_pulse;
                    spin_en_d = 1'b0;
                    state_d   = SHOW;
                    if (hit) begin
                        credit_d = (payout_sum > SUM_W'(CREDIT_MAX))
                                 ? CREDIT_W'(CREDIT_MAX) : payout_sum[CREDIT_W-1:0];
                    end
                end
            end
            SHOW: begin
                if (bus.restart_pulse) begin
                    win_d     = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = (credit_q == '0) ? OVER : IDLE;
                end
            end
            OVER: begin
                if (bus.restart_pulse) begin
                    credit_d = CREDIT_W'(CREDIT_INIT);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.state        = state_q;
    assign bus.credit       = credit_q;
    assign bus.bet          = bet_q;
    assign bus.result_digit = result_q;
    assign bus.win          = win_q;
    assign bus.spin_en      = spin_en_q;
    assign bus.start_rej    = start_rej_q;
    assign bus.timeout_flag = timeout_q;
endmodule

// File: tb/tb_arcade_round_ctrl.sv
// Directed bench for arcade_round_ctrl: three instances with different credit
// init values, all with an 8-cycle spin timeout.
module tb_arcade_round_ctrl;
    logic clk;
    logic rstn;

    logic       start_p [3];
    logic       stop_p  [3];
    logic       rst_p   [3];
    logic [6:0] bsel    [3];
    logic [3:0] gd      [3];
    logic [3:0] rd      [3];

    logic [1:0] st  [3];
    logic [8:0] cr  [3];
    logic [2:0] bt  [3];
    logic [3:0] res [3];
    logic       wn  [3];
    logic       sp  [3];
    logic       rej [3];
    logic       tmo [3];

    int n_assert;
    int n_fail;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        arcade_round_ctrl_if #(.CREDIT_W(9)) bus ();
        assign bus.start_pulse   = start_p[g];
        assign bus.stop_pulse    = stop_p[g];
        assign bus.restart_pulse = rst_p[g];
        assign bus.bet_sel       = bsel[g];
        assign bus.guess_digit   = gd[g];
        assign bus.rand_digit    = rd[g];
        assign st[g]  = bus.state;
        assign cr[g]  = bus.credit;
        assign bt[g]  = bus.bet;
        assign res[g] = bus.result_digit;
        assign wn[g]  = bus.win;
        assign sp[g]  = bus.spin_en;
        assign rej[g] = bus.start_rej;
        assign tmo[g] = bus.timeout_flag;

        arcade_round_ctrl #(
            .CREDIT_W    (9),
            .CREDIT_INIT ((g == 0) ? 200 : ((g == 1) ? 505 : 3)),
            .CREDIT_MAX  (511),
            .SPIN_TIMEOUT(8)
        ) u_dut (
            .clk (clk),
            .rstn(rstn),
            .bus (bus.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives the chosen pulses for exactly one cycle.
    task automatic pulse(input int k, input bit s, input bit p, input bit r);
        start_p[k] = s;
        stop_p[k]  = p;
        rst_p[k]   = r;
        @(negedge clk);
        start_p[k] = 1'b0;
        stop_p[k]  = 1'b0;
        rst_p[k]   = 1'b0;
    endtask

    task automatic reset_cycle();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        n_assert = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_p[k] = 1'b0; stop_p[k] = 1'b0; rst_p[k] = 1'b0;
            bsel[k] = 7'd0; gd[k] = 4'd0; rd[k] = 4'd0;
        end
        @(negedge clk);
        chk("rst_state", 32'(st[0]), 0);
        chk("rst_credit", 32'(cr[0]), 200);
        chk("rst_credit_b", 32'(cr[1]), 505);
        chk("rst_flags", {28'd0, wn[0], sp[0], rej[0], tmo[0]}, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a spin
        bsel[0] = 7'b0000111; gd[0] = 4'd2;
        pulse(0, 1, 0, 0);
        chk("pre_rst_state", 32'(st[0]), 1);
        chk("pre_rst_credit", 32'(cr[0]), 197);
        #2 rstn = 1'b0;
        #1;
        chk("async_state", 32'(st[0]), 0);
        chk("async_credit", 32'(cr[0]), 200);
        chk("async_spin_en", 32'(sp[0]), 0);
        chk("async_flags", {29'd0, wn[0], rej[0], tmo[0]}, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Winning round
        bsel[0] = 7'b0000111; gd[0] = 4'd5;
        pulse(0, 1, 0, 0);
        chk("win_spin_state", 32'(st[0]), 1);
        chk("win_spin_credit", 32'(cr[0]), 197);
        chk("win_bet", 32'(bt[0]), 3);
        chk("win_spin_en", 32'(sp[0]), 1);
        rd[0] = 4'd5;
        pulse(0, 0, 1, 0);
        chk("win_show_state", 32'(st[0]), 2);
        chk("win_flag", 32'(wn[0]), 1);
        chk("win_result", 32'(res[0]), 5);
        chk("win_credit", 32'(cr[0]), 203);
        chk("win_spin_en_off", 32'(sp[0]), 0);
        chk("win_tmo", 32'(tmo[0]), 0);
        pulse(0, 1, 0, 0);
        chk("show_ignore_start", 32'(st[0]), 2);
        pulse(0, 0, 0, 1);
        chk("win_restart_state", 32'(st[0]), 0);
        chk("win_cleared", 32'(wn[0]), 0);
        chk("result_hold", 32'(res[0]), 5);

        // Losing round from a fresh 200
        reset_cycle();
        bsel[0] = 7'b0000111; gd[0] = 4'd4; rd[0] = 4'd7;
        pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        chk("loss_state", 32'(st[0]), 2);
        chk("loss_win", 32'(wn[0]), 0);
        chk("loss_credit", 32'(cr[0]), 197);
        pulse(0, 0, 0, 1);
        chk("loss_idle", 32'(st[0]), 0);

        // Rejected starts: empty bet, invalid guess
        bsel[0] = 7'd0; gd[0] = 4'd3;
        pulse(0, 1, 0, 0);
        chk("rej0_pulse", 32'(rej[0]), 1);
        chk("rej0_state", 32'(st[0]), 0);
        chk("rej0_credit", 32'(cr[0]), 197);
        @(negedge clk);
        chk("rej0_one_cycle", 32'(rej[0]), 0);
        bsel[0] = 7'b1010001; gd[0] = 4'd12;
        pulse(0, 1, 0, 0);
        chk("rej_guess_pulse", 32'(rej[0]), 1);
        chk("rej_guess_state", 32'(st[0]), 0);
        chk("rej_guess_credit", 32'(cr[0]), 197);

        // Timeout with no stop: bet 1 -> credit 196
        bsel[0] = 7'b0100000; gd[0] = 4'd9; rd[0] = 4'd0;
        pulse(0, 1, 0, 0);
        chk("rej_cleared", 32'(rej[0]), 0);
        cnt = 0;
        for (int i = 0; i < 20 && sp[0] === 1'b1; i++) begin
            cnt++;
            @(negedge clk);
        end
        chk("timeout_len", 32'(cnt), 8);
        chk("timeout_state", 32'(st[0]), 2);
        chk("timeout_flag", 32'(tmo[0]), 1);
        chk("timeout_credit", 32'(cr[0]), 196);
        pulse(0, 0, 0, 1);
        chk("timeout_flag_clr", 32'(tmo[0]), 0);

        // start+stop together in IDLE: start taken; then stop on timeout cycle
        rd[0] = 4'd12;
        pulse(0, 1, 1, 0);
        chk("startstop_state", 32'(st[0]), 1);
        chk("startstop_credit", 32'(cr[0]), 195);
        repeat (7) @(negedge clk);
        chk("stop8_still_spin", 32'(st[0]), 1);
        pulse(0, 0, 1, 0);
        chk("stop8_state", 32'(st[0]), 2);
        chk("stop8_tmo", 32'(tmo[0]), 0);
        chk("stop8_result", 32'(res[0]), 12);
        chk("stop8_win", 32'(wn[0]), 0);

        // Saturating payout: 505 - 7 = 498, +14 -> 511
        bsel[1] = 7'b1111111; gd[1] = 4'd3; rd[1] = 4'd3;
        pulse(1, 1, 0, 0);
        chk("sat_spin_credit", 32'(cr[1]), 498);
        chk("sat_bet", 32'(bt[1]), 7);
        pulse(1, 0, 1, 0);
        chk("sat_win", 32'(wn[1]), 1);
        chk("sat_credit", 32'(cr[1]), 511);

        // Game over path with credit 3
        bsel[2] = 7'b1111111; gd[2] = 4'd1; rd[2] = 4'd2;
        pulse(2, 1, 0, 0);
        chk("rej_credit_pulse", 32'(rej[2]), 1);
        chk("rej_credit_state", 32'(st[2]), 0);
        chk("rej_credit_credit", 32'(cr[2]), 3);
        bsel[2] = 7'b0001111;
        pulse(2, 1, 0, 0);
        chk("rej_bet4_pulse", 32'(rej[2]), 1);
        bsel[2] = 7'b0000111;
        pulse(2, 0, 0, 1);
        chk("idle_ignore_restart", 32'(st[2]), 0);
        pulse(2, 1, 0, 0);
        chk("allin_state", 32'(st[2]), 1);
        chk("allin_credit", 32'(cr[2]), 0);
        pulse(2, 0, 1, 0);
        chk("allin_loss_credit", 32'(cr[2]), 0);
        pulse(2, 0, 0, 1);
        chk("over_state", 32'(st[2]), 3);
        pulse(2, 1, 1, 0);
        chk("over_ignore", 32'(st[2]), 3);
        chk("over_no_rej", 32'(rej[2]), 0);
        pulse(2, 0, 0, 1);
        chk("over_restart_state", 32'(st[2]), 0);
        chk("over_restart_credit", 32'(cr[2]), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
